mips_interrupt_controller: RTL and testbench
============================================

Name: mips_interrupt_controller

Overview:
- Sequences the 16-bit pipelined MIPS datapath on an external interrupt.
- Edge-latches the request lines and waits until no branch is unresolved. It then stalls and flushes fetch for a fixed drain window, saves the restart PC to EPC and redirects the PC to a per-source vector.
- On a return-from-interrupt it redirects the PC back to EPC.
- Drives the PC mux select override and the IF/ID flush alongside the existing hazard/forwarding logic.

Parameters:
- NUM_SRC, 4: number of interrupt sources; the active ID is clog2(NUM_SRC) bits.
- ADDR_W, 16: PC/address width.
- VEC_BASE, 16'h0040: vector address of source 0.
- VEC_STRIDE, 4: address spacing between consecutive source vectors.
- DRAIN_CYCLES, 3: number of cycles in DRAIN (minimum 1).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous reset, active-high.
- irq  in  NUM_SRC  level request lines; a rising edge sets pending.
- mask_we  in  1  writes irq_mask this cycle.
- mask_wdata  in  NUM_SRC  new mask; a 1 enables that source.
- pc_current  in  ADDR_W  address of the oldest unretired instruction (the restart point).
- branch_pending  in  1  a branch is in flight with its prediction unresolved.
- eret  in  1  return-from-interrupt decoded in ID; one-cycle pulse.
- stall_req  out  1  freezes PC and IF/ID.
- flush  out  1  squashes IF/ID.
- pc_redirect  out  1  overrides the PC mux with pc_target.
- pc_target  out  ADDR_W  redirect address.
- epc  out  ADDR_W  saved restart PC.
- in_service  out  1  a handler is running.
- active_id  out  clog2(NUM_SRC)  ID of the source being serviced.
- ack  out  NUM_SRC  one-hot one-cycle acknowledge.
- pending  out  NUM_SRC  pending register.

Behaviour:
- Reset (synchronous, active-high) sets: state IDLE, pending 0, irq_prev 0, irq_mask all-ones, epc 0, active_id 0, drain counter 0.
  - All outputs are 0 during and after reset.
  - Reset asserted in any state aborts the sequence that cycle, with no redirect.
- Edge latch:
  - pending[i] is set on irq[i] & ~irq_prev[i].
  - Because irq_prev resets to 0, a line held high through reset becomes pending on the first post-reset edge.
  - Masked sources still latch pending; they are simply not taken.
- Clearing: pending[id] clears in VECTOR. A new rising edge on the same bit in that cycle wins, so the bit stays set.
- The mask write takes effect on the next cycle.
- Outputs are Moore, decoded from the state register.
- FSM states: IDLE, DRAIN, VECTOR, SERVICE, RETURN.
  - IDLE → DRAIN when (pending & irq_mask) != 0 and branch_pending == 0.
    - Latches active_id = lowest set index (fixed priority, 0 highest).
    - Latches epc = pc_current.
    - Loads the drain counter with DRAIN_CYCLES-1.
  - DRAIN: stall_req = 1, flush = 1. Decrement the counter; at 0, go to VECTOR.
  - VECTOR (1 cycle): pc_redirect = 1, pc_target = VEC_BASE + active_id*VEC_STRIDE (mod 2^ADDR_W), flush = 1, ack[active_id] = 1, clear pending[active_id]. Then go to SERVICE.
  - SERVICE: in_service = 1. No nesting: new requests only accumulate in pending. On eret, go to RETURN.
  - RETURN (1 cycle): pc_redirect = 1, pc_target = epc, flush = 1, in_service = 1. Then go to IDLE.
    - A request pending at this point is taken from IDLE on the following cycle at the earliest.
- eret outside SERVICE is ignored.
- branch_pending is sampled only in IDLE; once DRAIN is entered the sequence completes.
- Latency from the first edge at which irq is sampled high, with DRAIN_CYCLES = D and branch_pending = 0:
  - pending set after E0;
  - DRAIN after E1;
  - VECTOR after E(1+D).
- When not redirecting, pc_target = 0.

Decomposition:
- Shared package mips_pkg holds:
  - the FSM state enum (irq_state_t);
  - ADDR_W;
  - the default VEC_BASE and VEC_STRIDE constants;
  - a vec_addr(id) function.
- One sub-module, mips_irq_edge_latch, owns irq_prev, pending set/clear priority and the lowest-index encoder.
- The controller FSM holds the drain counter, epc, active_id and output decode.

Test Plan:
- Reset / power-up: irq=0, hold reset for 2 cycles → all outputs 0 and pending=0. Then irq[1]=1 held through reset → pending=4'b0010 one edge after reset deasserts.
- Basic entry: pc_current=0x0123, pulse irq[2] → pending[2] after E0, DRAIN after E1 with stall_req=flush=1 for 3 cycles. Then VECTOR: pc_redirect=1, pc_target=0x0048, ack=4'b0100, epc=0x0123. Then in_service=1.
- Priority and mask: irq[3] and irq[1] rise together with mask=4'b1101 → source 3 taken (pc_target=0x004C) and pending[1] stays set. Next write mask=4'b1111 and eret → RETURN redirects to epc, then source 1 is taken (pc_target=0x0044).
- Branch hold-off: branch_pending=1 while irq[0] is pending → state stays IDLE with no stall. Drop branch_pending → DRAIN on the next edge with epc = pc_current at that edge.
- Simultaneous set/clear: re-pulse irq[2] exactly in its VECTOR cycle → ack[2]=1 and pending[2]=1 afterwards. Stray eret in IDLE → no redirect.
- Reset mid-operation: assert reset in the second DRAIN cycle → next cycle IDLE, stall_req=0, no pc_redirect, pending=0, epc=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS interrupt controller.
// Contents:
//   ADDR_W         - PC/address width
//   VEC_BASE_DEF   - default vector address of source 0
//   VEC_STRIDE_DEF - default spacing between consecutive source vectors
//   irq_state_t    - controller FSM state encoding
//   vec_addr()     - vector address for a source ID
package mips_pkg;

  localparam int unsigned ADDR_W         = 16;
  localparam logic [ADDR_W-1:0] VEC_BASE_DEF = 16'h0040;
  localparam int unsigned VEC_STRIDE_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_VECTOR,
    ST_SERVICE,
    ST_RETURN
  } irq_state_t;

  // Vector address = base + id * stride, wrapping at the address width.
  function automatic logic [ADDR_W-1:0] vec_addr(
    input int unsigned       id,
    input logic [ADDR_W-1:0] base   = VEC_BASE_DEF,
    input int unsigned       stride = VEC_STRIDE_DEF
  );
    return ADDR_W'(32'(base) + id * stride);
  endfunction

endpackage

// File: rtl/mips_irq_edge_latch.sv
// Rising-edge request latch with set-over-clear priority and a fixed-priority
// (index 0 highest) encoder over the enabled pending requests.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   irq_i       - level request lines
//   mask_i      - source enables used by the encoder
//   clr_i       - clear pending[clr_id_i] this cycle
//   clr_id_i    - index to clear
//   pending_o   - pending register
//   req_any_c   - some enabled source is pending (combinational)
//   req_id_c    - lowest enabled pending index (combinational)
module mips_irq_edge_latch #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_i,
  input  logic [NUM_SRC-1:0] mask_i,
  input  logic               clr_i,
  input  logic [ID_W-1:0]    clr_id_i,
  output logic [NUM_SRC-1:0] pending_o,
  output logic               req_any_c,
  output logic [ID_W-1:0]    req_id_c
);
  import mips_pkg::*;

  logic [NUM_SRC-1:0] irq_prev_q;
  logic [NUM_SRC-1:0] pending_q;
  logic [NUM_SRC-1:0] pending_d;
  logic [NUM_SRC-1:0] set_c;
  logic [NUM_SRC-1:0] clr_mask_c;
  logic [NUM_SRC-1:0] req_c;

  // A new edge on a bit being cleared wins: clear first, then OR in sets.
  always_comb begin
    set_c      = irq_i & ~irq_prev_q;
    clr_mask_c = '0;
    if (clr_i) begin
      clr_mask_c[clr_id_i] = 1'b1;
    end
    pending_d = (pending_q & ~clr_mask_c) | set_c;
  end

  // Lowest enabled pending index; scanning downward lets index 0 win.
  always_comb begin
    req_c     = pending_q & mask_i;
    req_any_c = |req_c;
    req_id_c  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_c[i]) begin
        req_id_c = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_prev_q <= '0;
      pending_q  <= '0;
    end else begin
      irq_prev_q <= irq_i;
      pending_q  <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/mips_interrupt_controller.sv
// Interrupt sequencer for the 16-bit pipelined MIPS datapath. Waits for
// unresolved branches to settle, stalls/flushes fetch for a fixed drain
// window, saves the restart PC to EPC and redirects to a per-source vector;
// eret redirects back to EPC. All outputs are registered Moore decodes.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   irq             - level request lines (rising edge sets pending)
//   mask_we/wdata   - mask write (1 = source enabled), effective next cycle
//   pc_current      - restart point captured into EPC on entry
//   branch_pending  - unresolved branch in flight; blocks entry from IDLE
//   eret            - return-from-interrupt pulse (honoured in SERVICE only)
//   stall_req/flush - freeze PC and IF/ID / squash IF/ID
//   pc_redirect     - override PC mux with pc_target
//   epc, in_service, active_id, ack, pending - status
module mips_interrupt_controller #(
  parameter int unsigned       NUM_SRC      = 4,
  parameter int unsigned       ADDR_W       = mips_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] VEC_BASE     = ADDR_W'(mips_pkg::VEC_BASE_DEF),
  parameter int unsigned       VEC_STRIDE   = mips_pkg::VEC_STRIDE_DEF,
  parameter int unsigned       DRAIN_CYCLES = 3,
  localparam int unsigned      ID_W         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic [ADDR_W-1:0]  pc_current,
  input  logic               branch_pending,
  input  logic               eret,
  output logic               stall_req,
  output logic               flush,
  output logic               pc_redirect,
  output logic [ADDR_W-1:0]  pc_target,
  output logic [ADDR_W-1:0]  epc,
  output logic               in_service,
  output logic [ID_W-1:0]    active_id,
  output logic [NUM_SRC-1:0] ack,
  output logic [NUM_SRC-1:0] pending
);
  import mips_pkg::*;

  localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  irq_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  epc_q, epc_d;
  logic [ID_W-1:0]    active_id_q, active_id_d;
  logic [NUM_SRC-1:0] mask_q;

  logic               stall_q, stall_d;
  logic               flush_q, flush_d;
  logic               redirect_q, redirect_d;
  logic [ADDR_W-1:0]  target_q, target_d;
  logic               in_service_q, in_service_d;
  logic [NUM_SRC-1:0] ack_q, ack_d;

  logic               req_any_c;
  logic [ID_W-1:0]    req_id_c;

  mips_irq_edge_latch #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_edge_latch (
    .clk       (clk),
    .reset     (reset),
    .irq_i     (irq),
    .mask_i    (mask_q),
    .clr_i     (state_q == ST_VECTOR),
    .clr_id_i  (active_id_q),
    .pending_o (pending),
    .req_any_c (req_any_c),
    .req_id_c  (req_id_c)
  );

  // Next-state logic; entry is only considered from IDLE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    epc_d       = epc_q;
    active_id_d = active_id_q;
    case (state_q)
      ST_IDLE: begin
        if (req_any_c && !branch_pending) begin
          state_d     = ST_DRAIN;
          active_id_d = req_id_c;
          epc_d       = pc_current;
          cnt_d       = CNT_W'(DRAIN_CYCLES - 1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = ST_VECTOR;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_VECTOR:  state_d = ST_SERVICE;
      ST_SERVICE: begin
        if (eret) begin
          state_d = ST_RETURN;
        end
      end
      ST_RETURN:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Moore output decode of the upcoming state, so registered outputs line up
  // with the state register.
  always_comb begin
    stall_d      = 1'b0;
    flush_d      = 1'b0;
    redirect_d   = 1'b0;
    target_d     = '0;
    in_service_d = 1'b0;
    ack_d        = '0;
    case (state_d)
      ST_DRAIN: begin
        stall_d = 1'b1;
        flush_d = 1'b1;
      end
      ST_VECTOR: begin
        redirect_d = 1'b1;
        flush_d    = 1'b1;
        target_d   = ADDR_W'(vec_addr(32'(active_id_d), VEC_BASE, VEC_STRIDE));
        ack_d      = NUM_SRC'(1) << active_id_d;
      end
      ST_SERVICE: begin
        in_service_d = 1'b1;
      end
      ST_RETURN: begin
        redirect_d   = 1'b1;
        flush_d      = 1'b1;
        target_d     = epc_d;
        in_service_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      epc_q        <= '0;
      active_id_q  <= '0;
      mask_q       <= '1;
      stall_q      <= 1'b0;
      flush_q      <= 1'b0;
      redirect_q   <= 1'b0;
      target_q     <= '0;
      in_service_q <= 1'b0;
      ack_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      epc_q        <= epc_d;
      active_id_q  <= active_id_d;
      if (mask_we) begin
        mask_q <= mask_wdata;
      end
      stall_q      <= stall_d;
      flush_q      <= flush_d;
      redirect_q   <= redirect_d;
      target_q     <= target_d;
      in_service_q <= in_service_d;
      ack_q        <= ack_d;
    end
  end

  assign stall_req   = stall_q;
  assign flush       = flush_q;
  assign pc_redirect = redirect_q;
  assign pc_target   = target_q;
  assign epc         = epc_q;
  assign in_service  = in_service_q;
  assign active_id   = active_id_q;
  assign ack         = ack_q;

endmodule

// File: tb/tb_mips_interrupt_controller.sv
// Self-checking bench for mips_interrupt_controller. The reference model
// tracks the interrupt sequence as "cycles elapsed since acceptance".
module tb_mips_interrupt_controller;

  localparam int D = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  irq = '0;
  logic        mask_we = 1'b0;
  logic [3:0]  mask_wdata = '0;
  logic [15:0] pc_current = '0;
  logic        branch_pending = 1'b0;
  logic        eret = 1'b0;
  logic        stall_req, flush, pc_redirect, in_service;
  logic [15:0] pc_target, epc;
  logic [1:0]  active_id;
  logic [3:0]  ack, pending;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: age = -1 idle, 0..D-1 draining, D vector,
  // D+1 servicing, D+2 returning.
  int          age = -1;
  int          m_id = 0;
  logic [15:0] m_epc = '0;
  logic [3:0]  m_pending = '0;
  logic [3:0]  m_mask = 4'hF;
  logic [3:0]  m_prev = '0;

  mips_interrupt_controller dut (
    .clk(clk), .reset(reset), .irq(irq), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .pc_current(pc_current),
    .branch_pending(branch_pending), .eret(eret),
    .stall_req(stall_req), .flush(flush), .pc_redirect(pc_redirect),
    .pc_target(pc_target), .epc(epc), .in_service(in_service),
    .active_id(active_id), .ack(ack), .pending(pending)
  );

  always #5 clk = ~clk;

  // Advance the model by one clock using the inputs as currently driven.
  task automatic model_step();
    logic [3:0] sel;
    logic [3:0] clr;
    clr = '0;
    if (reset) begin
      age = -1; m_id = 0; m_epc = '0; m_pending = '0; m_mask = 4'hF; m_prev = '0;
    end else begin
      if (age < 0) begin
        sel = m_pending & m_mask;
        if (sel != 0 && !branch_pending) begin
          for (int i = 3; i >= 0; i--) if (sel[i]) m_id = i;
          m_epc = pc_current;
          age = 0;
        end
      end else if (age < D) begin
        age = age + 1;
      end else if (age == D) begin
        clr[m_id] = 1'b1;
        age = D + 1;
      end else if (age == D + 1) begin
        if (eret) age = D + 2;
      end else begin
        age = -1;
      end
      m_pending = (m_pending & ~clr) | (irq & ~m_prev);
      m_prev = irq;
      if (mask_we) m_mask = mask_wdata;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [45:0] dut_vec();
    return {stall_req, flush, pc_redirect, pc_target, epc, in_service, active_id, ack, pending};
  endfunction

  function automatic logic [45:0] exp_vec();
    logic drn, vec, svc, ret;
    logic [15:0] tgt;
    logic [3:0] a;
    drn = (age >= 0) && (age < D);
    vec = (age == D);
    svc = (age == D + 1);
    ret = (age == D + 2);
    tgt = vec ? 16'h0040 + 16'(m_id) * 16'd4 : (ret ? m_epc : 16'h0000);
    a   = vec ? 4'(1 << m_id) : 4'h0;
    return {drn, drn | vec | ret, vec | ret, tgt, m_epc, svc | ret, 2'(m_id), a, m_pending};
  endfunction

  task automatic apply_reset();
    reset = 1'b1; irq = '0; mask_we = 1'b0; mask_wdata = '0;
    branch_pending = 1'b0; eret = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; irq = '0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL reset_hold[%0d]: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if ({stall_req, flush, pc_redirect, in_service, pc_target, ack, pending} !== '0) begin
      n_err++; $display("FAIL reset_zero: got %h want 0", {stall_req, flush, pc_redirect, in_service, pc_target, ack, pending});
    end
    irq = 4'b0010;
    cycle();
    reset = 1'b0;
    cycle();
    n_cmp++;
    if (pending !== 4'b0010) begin
      n_err++; $display("FAIL reset_held_irq: pending got %b want 0010", pending);
    end
  endtask

  task automatic test_basic_entry();
    apply_reset();
    pc_current = 16'h0123;
    irq = 4'b0100;
    cycle();
    n_cmp++;
    if (pending !== 4'b0100 || stall_req !== 1'b0) begin
      n_err++; $display("FAIL basic_pending: got p=%b s=%b want p=0100 s=0", pending, stall_req);
    end
    irq = '0;
    for (int k = 0; k < D; k++) begin
      cycle();
      n_cmp++;
      if (dut_vec() !== exp_vec() || {stall_req, flush} !== 2'b11) begin
        n_err++; $display("FAIL basic_drain[%0d]: got %h want %h", k, dut_vec(), exp_vec());
      end
    end
    cycle();
    n_cmp++;
    if ({pc_redirect, pc_target, ack, epc, flush} !== {1'b1, 16'h0048, 4'b0100, 16'h0123, 1'b1}) begin
      n_err++; $display("FAIL basic_vector: got r=%b t=%h a=%b e=%h want r=1 t=0048 a=0100 e=0123",
                        pc_redirect, pc_target, ack, epc);
    end
    cycle();
    n_cmp++;
    if (in_service !== 1'b1 || pending !== 4'b0000 || pc_redirect !== 1'b0) begin
      n_err++; $display("FAIL basic_service: got svc=%b p=%b r=%b want 1 0000 0", in_service, pending, pc_redirect);
    end
    eret = 1'b1;
    cycle();
    eret = 1'b0;
    n_cmp++;
    if ({pc_redirect, pc_target, flush} !== {1'b1, 16'h0123, 1'b1}) begin
      n_err++; $display("FAIL basic_return: got r=%b t=%h want r=1 t=0123", pc_redirect, pc_target);
    end
    cycle();
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_err++; $display("FAIL basic_idle: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_priority_mask();
    apply_reset();
    pc_current = 16'h0200;
    mask_we = 1'b1; mask_wdata = 4'b1101;
    cycle();
    mask_we = 1'b0;
    irq = 4'b1010;
    cycle();
    irq = '0;
    for (int k = 0; k <= D; k++) begin
      cycle();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL prio_seq[%0d]: got %h want %h", k, dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (pc_target !== 16'h004C || pending[1] !== 1'b1 || ack !== 4'b1000) begin
      n_err++; $display("FAIL prio_vector3: got t=%h p=%b a=%b want t=004C p[1]=1 a=1000", pc_target, pending, ack);
    end
    cycle();
    mask_we = 1'b1; mask_wdata = 4'b1111; eret = 1'b1;
    cycle();
    mask_we = 1'b0; eret = 1'b0;
    n_cmp++;
    if ({pc_redirect, pc_target} !== {1'b1, 16'h0200}) begin
      n_err++; $display("FAIL prio_return: got r=%b t=%h want r=1 t=0200", pc_redirect, pc_target);
    end
    cycle();
    for (int k = 0; k <= D; k++) begin
      cycle();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL prio_seq2[%0d]: got %h want %h", k, dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (pc_target !== 16'h0044 || ack !== 4'b0010) begin
      n_err++; $display("FAIL prio_vector1: got t=%h a=%b want t=0044 a=0010", pc_target, ack);
    end
  endtask

  task automatic test_branch_holdoff();
    apply_reset();
    branch_pending = 1'b1;
    irq = 4'b0001;
    cycle();
    irq = '0;
    for (int k = 0; k < 3; k++) begin
      pc_current = 16'($urandom);
      cycle();
      n_cmp++;
      if (dut_vec() !== exp_vec() || stall_req !== 1'b0) begin
        n_err++; $display("FAIL branch_hold[%0d]: got %h want %h", k, dut_vec(), exp_vec());
      end
    end
    branch_pending = 1'b0;
    pc_current = 16'h0777;
    cycle();
    n_cmp++;
    if ({stall_req, epc} !== {1'b1, 16'h0777}) begin
      n_err++; $display("FAIL branch_release: got s=%b e=%h want s=1 e=0777", stall_req, epc);
    end
    pc_current = 16'h0999;
    for (int k = 0; k < D + 1; k++) begin
      cycle();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL branch_seq[%0d]: got %h want %h", k, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_set_clear();
    apply_reset();
    irq = 4'b0100;
    cycle();
    irq = '0;
    for (int k = 0; k <= D; k++) cycle();
    n_cmp++;
    if (ack !== 4'b0100 || pc_redirect !== 1'b1) begin
      n_err++; $display("FAIL setclr_vector: got a=%b r=%b want a=0100 r=1", ack, pc_redirect);
    end
    irq = 4'b0100;
    cycle();
    irq = '0;
    n_cmp++;
    if (pending[2] !== 1'b1 || in_service !== 1'b1) begin
      n_err++; $display("FAIL setclr_pending: got p=%b svc=%b want p[2]=1 svc=1", pending, in_service);
    end
    apply_reset();
    eret = 1'b1;
    cycle();
    eret = 1'b0;
    n_cmp++;
    if (pc_redirect !== 1'b0 || dut_vec() !== exp_vec()) begin
      n_err++; $display("FAIL stray_eret: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    pc_current = 16'h0555;
    irq = 4'b0001;
    cycle();
    irq = '0;
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    n_cmp++;
    if ({stall_req, pc_redirect, pending, epc} !== '0) begin
      n_err++; $display("FAIL reset_mid: got s=%b r=%b p=%b e=%h want all 0", stall_req, pc_redirect, pending, epc);
    end
    cycle();
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_err++; $display("FAIL reset_mid_after: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int k = 0; k < 600; k++) begin
      reset          = ($urandom_range(0, 63) == 0);
      irq            = 4'($urandom);
      mask_we        = ($urandom_range(0, 15) == 0);
      mask_wdata     = 4'($urandom);
      branch_pending = ($urandom_range(0, 3) == 0);
      eret           = ($urandom_range(0, 7) == 0);
      pc_current     = 16'($urandom);
      cycle();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL random[%0d]: got %h want %h", k, dut_vec(), exp_vec());
      end
    end
    reset = 1'b0; mask_we = 1'b0; eret = 1'b0; branch_pending = 1'b0; irq = '0;
  endtask

  initial begin
    test_reset();
    test_basic_entry();
    test_priority_mask();
    test_branch_holdoff();
    test_set_clear();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
